gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
Parametrised gshare branch direction predictor for the fetch stage. Indexes a pattern history table (PHT) of saturating counters with the PC-derived index XORed with a speculative global history register (GHR). The GHR is updated at predict time and restored from a caller-supplied checkpoint on a mispredict. A sequenced flush clears the table without a reset.

Parameters:
IDX_WIDTH, 10, PHT index width; the PHT holds 2^IDX_WIDTH counters
HIST_LEN, 10, GHR length; must satisfy 2 <= HIST_LEN <= IDX_WIDTH
CTR_WIDTH, 2, saturating counter width; must be >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pred_req  in  1  request a prediction this cycle
pred_pc_idx  in  IDX_WIDTH  PC-derived index
pred_valid  out  1  prediction valid; one-cycle pulse
pred_taken  out  1  predicted direction
pred_tag  out  IDX_WIDTH  PHT index used; carried down the pipe
pred_hist  out  HIST_LEN  GHR before this prediction's shift (checkpoint)
upd_valid  in  1  branch resolved
upd_tag  in  IDX_WIDTH  pred_tag of the resolved branch
upd_taken  in  1  actual outcome
upd_mispredict  in  1  prediction was wrong; qualified by upd_valid
upd_hist  in  HIST_LEN  pred_hist of the resolved branch
flush_req  in  1  start a table clear
busy  out  1  clear in progress

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - every counter = INIT_CTR (2^(CTR_WIDTH-1)-1, weakly not-taken); GHR = 0; state IDLE.
  - pred_valid = 0, pred_taken = 0, pred_tag = 0, pred_hist = 0, busy = 0.
  - Reset asserted mid-clear aborts the sweep; the block comes out of reset fully initialised.
- Index: idx = pred_pc_idx ^ zero_extend(GHR). The GHR occupies the LSBs.
- Predict, 1-cycle latency: pred_req high in cycle N (state IDLE) registers the following outputs, visible in N+1:
  - pred_valid = 1
  - pred_taken = MSB of PHT[idx], read before any write at the N edge (no write-to-read forwarding)
  - pred_tag = idx
  - pred_hist = GHR at N
  - pred_valid = 0 in any cycle with no accepted request.
- Speculative GHR: an accepted pred_req sets GHR <= {GHR[HIST_LEN-2:0], predicted bit}.
- Update, upd_valid in IDLE: PHT[upd_tag] saturating-increments if upd_taken, else saturating-decrements. Clamped at 0 and 2^CTR_WIDTH-1; no wrap.
- Mispredict: upd_valid and upd_mispredict set GHR <= {upd_hist[HIST_LEN-2:0], upd_taken}. This has priority over a same-cycle pred_req shift. That prediction is still issued, using the pre-restore GHR, but its shift is discarded.
- Same-cycle predict and update to one index: the prediction sees the old counter value and the update is applied.
- Flush FSM:
  - IDLE --flush_req--> CLEAR.
  - CLEAR: a sweep counter writes INIT_CTR to one entry per cycle, starting at 0. GHR is cleared on entry.
  - After entry 2^IDX_WIDTH-1 is written, CLEAR --> IDLE. busy = 1 exactly for the 2^IDX_WIDTH CLEAR cycles.
  - In CLEAR: pred_req is ignored (pred_valid stays 0); upd_valid and flush_req are ignored.
  - flush_req together with pred_req or upd_valid in IDLE: the predict and update complete normally, and CLEAR starts in the next cycle.
- Sweep counter: IDX_WIDTH+1 bits; terminal detect on all-ones in the low IDX_WIDTH bits.

Decomposition:
- Package gshare_pkg holds:
  - state enum {IDLE, CLEAR}
  - parameterised INIT_CTR constant / function
  - sat_inc/sat_dec functions
- Sub-module gshare_pht holds the counter array with:
  - async reset to INIT_CTR
  - one combinational read port
  - one read-modify-write update port
  - one clear-write port, which has priority over the update
- The top level holds the GHR, the index hash, the output registers and the FSM.

Test Plan:
(defaults IDX_WIDTH=10, HIST_LEN=10, CTR_WIDTH=2)
1. After reset, pred_req with pred_pc_idx=0x005 -> next cycle pred_valid=1, pred_taken=0, pred_tag=0x005, pred_hist=0x000; GHR stays 0x000.
2. Two updates, upd_tag=0x005 upd_taken=1 (counter 01->10->11); then GHR=0, pred_pc_idx=0x005 -> pred_taken=1, pred_tag=0x005; GHR then 0x001.
3. Saturation: three more taken updates keep 0x005 at 11; one not-taken update -> 10, still pred_taken=1; three more not-taken -> 00, and a further not-taken stays 00 with pred_taken=0.
4. Mispredict restore: after three predictions, upd_mispredict with upd_hist=0x2AA, upd_taken=0 -> GHR=0x154; pred_pc_idx=0x000 -> pred_tag=0x154, pred_hist=0x154.
5. Same-cycle pred_req (GHR=0x003, pred_pc_idx=0x010) and mispredict (upd_hist=0x001, upd_taken=1) -> pred_tag=0x013, pred_hist=0x003; GHR afterwards=0x003 (restored value, not shifted).
6. Flush after training 0x005: busy=1 for exactly 1024 cycles and pred_req is ignored throughout; afterwards 0x005 predicts 0. A second run asserts rst at sweep entry 300 -> busy=0 immediately and all entries read weakly-not-taken.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
package gshare_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Weakly not-taken starting value for a counter of width w.
  function automatic logic [31:0] init_ctr(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Saturating increment: clamps at 2^w-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

  // Saturating decrement: clamps at 0.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: array of saturating counters with one combinational
// read port, one read-modify-write update port and one clear-write port.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int IDX_WIDTH = 10,
  parameter int CTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd_en,
  input  logic [IDX_WIDTH-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic                 clr_en,
  input  logic [IDX_WIDTH-1:0] clr_idx
);

  localparam int                 DEPTH = 1 << IDX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT = CTR_WIDTH'(init_ctr(CTR_WIDTH));

  logic [CTR_WIDTH-1:0] mem [DEPTH];
  logic [CTR_WIDTH-1:0] upd_next;

  // Direction is the counter MSB; reads see the value before this edge's write.
  assign rd_taken = mem[rd_idx][CTR_WIDTH-1];

  // Next value of the counter being trained.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    upd_next = mem[upd_idx];
    if (upd_taken) upd_next = CTR_WIDTH'(sat_inc(32'(mem[upd_idx]), CTR_WIDTH));
    else           upd_next = CTR_WIDTH'(sat_dec(32'(mem[upd_idx])));
  end

  // Counter storage: reset to INIT, clear-write wins over training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is built from flops rather than a RAM macro so that
      // reset can bring every entry to INIT at once; a RAM could not be reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (clr_en) begin
      // NOTE: state uses non-blocking assignments so all flops update together.
      mem[clr_idx] <= INIT;
    end else if (upd_en) begin
      mem[upd_idx] <= upd_next;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: speculative GHR, PC^GHR hash, registered
// prediction outputs and a sequenced table-clear FSM.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int IDX_WIDTH = 10,
  parameter int HIST_LEN  = 10,
  parameter int CTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_req,
  input  logic [IDX_WIDTH-1:0] pred_pc_idx,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [IDX_WIDTH-1:0] pred_tag,
  output logic [HIST_LEN-1:0]  pred_hist,
  input  logic                 upd_valid,
  input  logic [IDX_WIDTH-1:0] upd_tag,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  input  logic [HIST_LEN-1:0]  upd_hist,
  input  logic                 flush_req,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [IDX_WIDTH:0]   sweep_q, sweep_d;
  logic [HIST_LEN-1:0]  ghr_q, ghr_d;
  logic [IDX_WIDTH-1:0] pred_idx;
  logic                 rd_taken;
  logic                 idle;
  logic                 pred_acc;
  logic                 upd_acc;
  logic                 restore;
  logic                 clr_en;

  assign idle     = (state_q == IDLE);
  assign pred_acc = idle && pred_req;
  assign upd_acc  = idle && upd_valid;
  assign restore  = upd_acc && upd_mispredict;
  assign pred_idx = pred_pc_idx ^ IDX_WIDTH'(ghr_q);
  assign busy     = (state_q == CLEAR);

  gshare_pht #(
    .IDX_WIDTH (IDX_WIDTH),
    .CTR_WIDTH (CTR_WIDTH)
  ) u_pht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pred_idx),
    .rd_taken  (rd_taken),
    .upd_en    (upd_acc),
    .upd_idx   (upd_tag),
    .upd_taken (upd_taken),
    .clr_en    (clr_en),
    .clr_idx   (sweep_q[IDX_WIDTH-1:0])
  );

  // Flush FSM next state and sweep counter; one entry cleared per CLEAR cycle.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        clr_en  = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q[IDX_WIDTH-1:0]) begin
          state_d = IDLE;
          sweep_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // GHR next value: flush entry clears, mispredict restore beats speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (idle && flush_req) ghr_d = '0;
    else if (restore)      ghr_d = HIST_LEN'({upd_hist, upd_taken});
    else if (pred_acc)     ghr_d = HIST_LEN'({ghr_q, rd_taken});
  end

  // FSM state, sweep counter and GHR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Prediction output registers; valid pulses for one cycle per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_tag   <= '0;
      pred_hist  <= '0;
    end else begin
      pred_valid <= pred_acc;
      if (pred_acc) begin
        pred_taken <= rd_taken;
        pred_tag   <= pred_idx;
        pred_hist  <= ghr_q;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus random
// traffic, checked by a scoreboard fed from a table-level reference model.
module tb_gshare_predictor;

  localparam int IW    = 10;
  localparam int HL    = 10;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << IW;
  localparam int INIT  = (1 << (CW - 1)) - 1;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int HMASK = (1 << HL) - 1;

  logic          clk;
  logic          rst;
  logic          pred_req;
  logic [IW-1:0] pred_pc_idx;
  logic          pred_valid;
  logic          pred_taken;
  logic [IW-1:0] pred_tag;
  logic [HL-1:0] pred_hist;
  logic          upd_valid;
  logic [IW-1:0] upd_tag;
  logic          upd_taken;
  logic          upd_mispredict;
  logic [HL-1:0] upd_hist;
  logic          flush_req;
  logic          busy;

  gshare_predictor #(.IDX_WIDTH(IW), .HIST_LEN(HL), .CTR_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_req       (pred_req),
    .pred_pc_idx    (pred_pc_idx),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_tag       (pred_tag),
    .pred_hist      (pred_hist),
    .upd_valid      (upd_valid),
    .upd_tag        (upd_tag),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .upd_hist       (upd_hist),
    .flush_req      (flush_req),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int taken;
    int tag;
    int hist;
  } exp_t;

  exp_t sb_q[$];
  int   model_pht[DEPTH];
  int   model_ghr;
  int   busy_left;
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_pht[i] = INIT;
    model_ghr = 0;
    busy_left = 0;
  endfunction

  // One clock edge of the predictor, described at table level.
  task automatic model_step(input bit pr, input int pc, input bit uv, input int ut,
                            input bit tk, input bit mp, input int uh, input bit fl);
    int   idx;
    int   bit_p;
    int   ghr_n;
    exp_t e;
    if (busy_left > 0) begin
      busy_left--;
      return;
    end
    ghr_n = model_ghr;
    if (pr) begin
      idx     = (pc ^ model_ghr) & (DEPTH - 1);
      bit_p   = (model_pht[idx] > INIT) ? 1 : 0;
      e.taken = bit_p;
      e.tag   = idx;
      e.hist  = model_ghr;
      sb_q.push_back(e);
      ghr_n   = ((model_ghr << 1) | bit_p) & HMASK;
    end
    if (uv) begin
      if (tk) model_pht[ut] = (model_pht[ut] < CMAX) ? model_pht[ut] + 1 : CMAX;
      else    model_pht[ut] = (model_pht[ut] > 0) ? model_pht[ut] - 1 : 0;
      if (mp) ghr_n = ((uh << 1) | (tk ? 1 : 0)) & HMASK;
    end
    if (fl) begin
      ghr_n     = 0;
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_pht[i] = INIT;
    end
    model_ghr = ghr_n;
  endtask

  // Drive one cycle of inputs, let the edge pass, then advance the model.
  task automatic cycle(input bit pr, input int pc, input bit uv, input int ut,
                       input bit tk, input bit mp, input int uh, input bit fl);
    pred_req       = pr;
    pred_pc_idx    = IW'(pc);
    upd_valid      = uv;
    upd_tag        = IW'(ut);
    upd_taken      = tk;
    upd_mispredict = mp;
    upd_hist       = HL'(uh);
    flush_req      = fl;
    @(posedge clk);
    #1;
    model_step(pr, pc & (DEPTH - 1), uv, ut & (DEPTH - 1), tk, mp, uh & HMASK, fl);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input int tag, input bit tk);
    cycle(0, 0, 1, tag, tk, 0, 0, 0);
  endtask

  task automatic rand_cycle(input bit allow_flush);
    cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom,
          allow_flush && ($urandom_range(0, 799) == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    model_reset();
    #1;
    check("reset busy", busy, 0);
    check("reset pred_valid", pred_valid, 0);
    check("reset pred_taken", pred_taken, 0);
    check("reset pred_tag", pred_tag, 0);
    check("reset pred_hist", pred_hist, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check("busy", busy, (busy_left > 0) ? 1 : 0);
      if (sb_q.size() == 0) begin
        if (pred_valid) check("pred_valid unexpected", pred_valid, 0);
      end else begin
        e = sb_q.pop_front();
        check("pred_valid", pred_valid, 1);
        check("pred_taken", pred_taken, e.taken);
        check("pred_tag", pred_tag, e.tag);
        check("pred_hist", pred_hist, e.hist);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    model_reset();
    cycle_inputs_zero();
    #2;
    do_reset();

    // Fresh table predicts weakly not-taken; GHR stays zero.
    cycle(1, 'h005, 0, 0, 0, 0, 0, 0);
    check("t1 taken", pred_taken, 0);
    check("t1 tag", pred_tag, 'h005);
    check("t1 hist", pred_hist, 'h000);

    // Two taken updates push 0x005 to strongly taken.
    train('h005, 1);
    train('h005, 1);
    cycle(1, 'h005, 0, 0, 0, 0, 0, 0);
    check("t2 taken", pred_taken, 1);
    check("t2 tag", pred_tag, 'h005);
    check("t2 hist", pred_hist, 'h000);

    // Saturation at both ends.
    repeat (3) train('h005, 1);
    train('h005, 0);
    cycle(1, 'h005 ^ model_ghr, 0, 0, 0, 0, 0, 0);
    check("t3 weak taken", pred_taken, 1);
    check("t3 tag", pred_tag, 'h005);
    repeat (4) train('h005, 0);
    cycle(1, 'h005 ^ model_ghr, 0, 0, 0, 0, 0, 0);
    check("t3 floor", pred_taken, 0);

    // Mispredict restore.
    cycle(1, 'h011, 0, 0, 0, 0, 0, 0);
    cycle(1, 'h022, 0, 0, 0, 0, 0, 0);
    cycle(1, 'h033, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 'h2AA, 0);
    cycle(1, 'h000, 0, 0, 0, 0, 0, 0);
    check("t4 tag", pred_tag, 'h154);
    check("t4 hist", pred_hist, 'h154);

    // Restore beats same-cycle speculative shift.
    cycle(0, 0, 1, 'h3F0, 1, 1, 'h001, 0);
    cycle(1, 'h010, 1, 'h3F0, 1, 1, 'h001, 0);
    check("t5 tag", pred_tag, 'h013);
    check("t5 hist", pred_hist, 'h003);
    cycle(1, 'h000, 0, 0, 0, 0, 0, 0);
    check("t5 ghr after", pred_hist, 'h003);

    // Full flush: busy for exactly DEPTH cycles, requests ignored.
    repeat (3) train('h005, 1);
    cycle(1, 'h040, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    while (busy && cnt < 2 * DEPTH) begin
      cnt++;
      cycle(1, $urandom, 1, 'h005, 1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end
    check("flush busy cycles", cnt, DEPTH);
    cycle(1, 'h005, 0, 0, 0, 0, 0, 0);
    check("post flush taken", pred_taken, 0);
    check("post flush hist", pred_hist, 0);

    // Reset in the middle of a sweep.
    repeat (3) train('h005, 1);
    repeat (3) train('h3FF, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (300) cycle(1, $urandom, 1, 'h3FF, 1, 0, 0, 0);
    do_reset();
    cycle(1, 'h005, 0, 0, 0, 0, 0, 0);
    check("mid reset 0x005", pred_taken, 0);
    cycle(1, 'h3FF ^ model_ghr, 0, 0, 0, 0, 0, 0);
    check("mid reset 0x3FF", pred_taken, 0);
    repeat (20) cycle(1, $urandom, 0, 0, 0, 0, 0, 0);

    // Random traffic, including occasional flushes.
    repeat (3000) rand_cycle(1'b1);
    cnt = 0;
    while (busy_left > 0 && cnt < 2 * DEPTH) begin
      cnt++;
      rand_cycle(1'b0);
    end
    repeat (4) idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic cycle_inputs_zero();
    pred_req       = 1'b0;
    pred_pc_idx    = '0;
    upd_valid      = 1'b0;
    upd_tag        = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    upd_hist       = '0;
    flush_req      = 1'b0;
  endtask

endmodule
